// File: rtl/hw02_dot_seq.sv
// Upstream sequencer for the hw02 register-file datapath: walks N_ELEM (a,b) pairs
// through a->R1, b->R2, R1*R2->R3. Define HW02_DOT_ACC_EN to accumulate R3 into dot_out.
module hw02_dot_seq #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 4,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              elem_valid,
  output logic              elem_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] r3_in,
  output logic [DATA_W-1:0] data,
  output logic [2:0]        sel,
  output logic [3:0]        load,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  dot_out
);

  localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_MUL    = 3'd4,
`ifdef HW02_DOT_ACC_EN
    S_ACC    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] a_lat_r;
  logic [DATA_W-1:0] b_lat_r;
  logic              elem_ready_r;
  logic [DATA_W-1:0] data_r;
  logic [2:0]        sel_r;
  logic [3:0]        load_r;
  logic              busy_r;
  logic              done_r;

`ifdef HW02_DOT_ACC_EN
  logic [ACC_W-1:0]  dot_r;
  assign dot_out = dot_r;
`else
  logic              unused_r3_s;
  assign unused_r3_s = ^r3_in;
  assign dot_out     = {ACC_W{1'b0}};
`endif

  assign elem_ready = elem_ready_r;
  assign data       = data_r;
  assign sel        = sel_r;
  assign load       = load_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      count_r      <= {CNT_W{1'b0}};
      a_lat_r      <= {DATA_W{1'b0}};
      b_lat_r      <= {DATA_W{1'b0}};
      elem_ready_r <= 1'b0;
      data_r       <= {DATA_W{1'b0}};
      sel_r        <= 3'd0;
      load_r       <= 4'b0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef HW02_DOT_ACC_EN
      dot_r        <= {ACC_W{1'b0}};
`endif
    end else begin
      elem_ready_r <= 1'b0;
      data_r       <= {DATA_W{1'b0}};
      sel_r        <= 3'd0;
      load_r       <= 4'b0000;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r      <= S_WAIT;
            count_r      <= {CNT_W{1'b0}};
            elem_ready_r <= 1'b1;
`ifdef HW02_DOT_ACC_EN
            dot_r        <= {ACC_W{1'b0}};
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_WAIT: begin
          if (elem_valid) begin
            a_lat_r <= a_in;
            b_lat_r <= b_in;
            state_r <= S_LOAD_A;
            sel_r   <= 3'd4;
            load_r  <= 4'b0010;
            data_r  <= a_in;
          end else begin
            elem_ready_r <= 1'b1;
          end
        end
        S_LOAD_A: begin
          state_r <= S_LOAD_B;
          sel_r   <= 3'd4;
          load_r  <= 4'b0100;
          data_r  <= b_lat_r;
        end
        S_LOAD_B: begin
          state_r <= S_MUL;
          sel_r   <= 3'd3;
          load_r  <= 4'b1000;
        end
`ifdef HW02_DOT_ACC_EN
        S_MUL: begin
          state_r <= S_ACC;
        end
        // R3 now holds this pair's product; fold it in and close out the element.
        S_ACC: begin
          dot_r <= dot_r + ACC_W'(r3_in);
          if (count_r == LAST_IDX) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            count_r      <= count_r + CNT_W'(1);
            state_r      <= S_WAIT;
            elem_ready_r <= 1'b1;
          end
        end
`else
        S_MUL: begin
          if (count_r == LAST_IDX) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            count_r      <= count_r + CNT_W'(1);
            state_r      <= S_WAIT;
            elem_ready_r <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hw02_dot_seq.sv
// Scoreboard bench for hw02_dot_seq with a behavioural R1/R2/R3 datapath model.
`timescale 1ns/1ps
module tb_hw02_dot_seq;
  localparam int DATA_W = 8;
  localparam int N_ELEM = 4;
  localparam int ACC_W  = 18;
`ifdef HW02_DOT_ACC_EN
  localparam int ACC_STEPS = 1;
`else
  localparam int ACC_STEPS = 0;
`endif
  localparam int EXP_LAT = N_ELEM * (4 + ACC_STEPS) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic elem_valid = 1'b0;
  logic [DATA_W-1:0] a_in = 8'd0;
  logic [DATA_W-1:0] b_in = 8'd0;
  logic elem_ready, busy, done;
  logic [DATA_W-1:0] data;
  logic [2:0] sel;
  logic [3:0] load;
  logic [ACC_W-1:0] dot_out;

  logic w_ready, w_busy, w_done;
  logic [DATA_W-1:0] w_data;
  logic [2:0] w_sel;
  logic [3:0] w_load;
  logic [8:0] w_dot;

  logic [DATA_W-1:0] r0 = 8'd0, r1 = 8'd0, r2 = 8'd0, r3 = 8'd0;
  logic [DATA_W-1:0] mux_s;
  logic [2*DATA_W-1:0] prod_s;

  hw02_dot_seq #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .a_in(a_in), .b_in(b_in), .r3_in(r3), .data(data), .sel(sel), .load(load),
    .busy(busy), .done(done), .dot_out(dot_out));

  // Second instance sees a datapath stuck at R3=255 and a 9-bit accumulator.
  hw02_dot_seq #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .ACC_W(9)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .elem_valid(elem_valid), .elem_ready(w_ready),
    .a_in(a_in), .b_in(b_in), .r3_in(8'hFF), .data(w_data), .sel(w_sel), .load(w_load),
    .busy(w_busy), .done(w_done), .dot_out(w_dot));

  always #5 clk = ~clk;

  assign prod_s = r1 * r2;
  assign mux_s  = (sel == 3'd4) ? data : (sel == 3'd3) ? prod_s[DATA_W-1:0] : 8'd0;

  always @(posedge clk) begin
    if (load[0]) r0 <= mux_s;
    if (load[1]) r1 <= mux_s;
    if (load[2]) r2 <= mux_s;
    if (load[3]) r3 <= mux_s;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] load;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Every datapath write must match the next expected write in order.
  always @(negedge clk) begin
    wr_t w;
    if (load != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("extra_write", {17'd0, sel, load, data}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("write", {17'd0, sel, load, data}, {17'd0, w});
      end
    end
    if (done) done_cnt++;
  end

  logic [7:0] va [4] = '{8'd2, 8'd5, 8'd8, 8'd1};
  logic [7:0] vb [4] = '{8'd5, 8'd3, 8'd10, 8'd7};

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (elem_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back({3'd4, 4'b0010, a});
    exp_q.push_back({3'd4, 4'b0100, b});
    exp_q.push_back({3'd3, 4'b1000, 8'd0});
  endtask

  task automatic do_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    elem_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic run(input int stall_pair, input bit poke_start);
    int c0, dcyc;
    bit ok, seen;
    logic [17:0] sum;
    logic [8:0] wsum;
    logic [15:0] p;
    sum = 18'd0;
    wsum = 9'd0;
    do_start(c0);
    for (int i = 0; i < N_ELEM; i++) begin
      a_in = va[i];
      b_in = vb[i];
      if (i == stall_pair) begin
        elem_valid = 1'b0;
        if (poke_start) start = 1'b1;
      end
      wait_ready(ok);
      check("ready_seen", {31'd0, ok}, 32'd1);
      if (!ok) return;
      if (i == stall_pair) begin
        repeat (3) begin
          check("bp_ready", {31'd0, elem_ready}, 32'd1);
          check("bp_load", {28'd0, load}, 32'd0);
          @(negedge clk);
        end
        start = 1'b0;
        elem_valid = 1'b1;
      end
      push_pair(va[i], vb[i]);
      p = va[i] * vb[i];
      sum = sum + {10'd0, p[7:0]};
      wsum = wsum + 9'd255;
      @(posedge clk);
      #1;
    end
    elem_valid = 1'b0;
    seen = 1'b0;
    dcyc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (stall_pair < 0) check("latency", dcyc - c0 + 1, EXP_LAT);
`ifdef HW02_DOT_ACC_EN
    check("dot", {14'd0, dot_out}, {14'd0, sum});
    check("dot_wrap", {23'd0, w_dot}, {23'd0, wsum});
`else
    check("dot", {14'd0, dot_out}, 32'd0);
    check("dot_wrap", {23'd0, w_dot}, 32'd0);
`endif
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_end", {31'd0, busy}, 32'd0);
`ifdef HW02_DOT_ACC_EN
    check("dot_hold", {14'd0, dot_out}, {14'd0, sum});
`else
    check("dot_hold", {14'd0, dot_out}, 32'd0);
`endif
    check("wr_drain", exp_q.size(), 32'd0);
  endtask

  task automatic midrun_reset();
    int c0, dc;
    bit ok;
    do_start(c0);
    a_in = va[0];
    b_in = vb[0];
    wait_ready(ok);
    check("ready_seen", {31'd0, ok}, 32'd1);
    push_pair(va[0], vb[0]);
    @(posedge clk);
    #1;
    a_in = va[1];
    b_in = vb[1];
    wait_ready(ok);
    check("ready_seen", {31'd0, ok}, 32'd1);
    exp_q.push_back({3'd4, 4'b0010, va[1]});
    exp_q.push_back({3'd4, 4'b0100, vb[1]});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("in_load_b", {28'd0, load}, 32'd4);
    rst = 1'b1;
    dc = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    elem_valid = 1'b0;
    @(negedge clk);
    check("mr_load", {28'd0, load}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_ready", {31'd0, elem_ready}, 32'd0);
    check("mr_dot", {14'd0, dot_out}, 32'd0);
    check("mr_sel_data", {21'd0, sel, data}, 32'd0);
    repeat (3) @(negedge clk);
    check("mr_no_done", done_cnt, dc);
    check("mr_busy_idle", {31'd0, busy}, 32'd0);
    check("mr_wr_drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {13'd0, elem_ready, busy, done, sel, load, data}, 32'd0);
    check("rst_dot", {14'd0, dot_out}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_outs", {16'd0, elem_ready, done, sel, load, data}, 32'd0);
    end
    run(-1, 1'b0);
    run(1, 1'b1);
    midrun_reset();
    run(-1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
